rf_write_arbiter: RTL

Write-port arbiter and sequencer for the register file. It accepts write requests from two sources: the pipeline writeback stage (`wb`) and the load-return path (`ld`). Each source uses a valid/ready handshake. Accepted writes are buffered in a 4-entry in-order queue and drained one per cycle as one-hot `WriteReg` strobes plus `WriteData` onto the register bank's single write port. A per-register `pending` bitmap is exported to the hazard unit so that reads of in-flight registers stall.

---
 rtl/rf_pkg.sv | 26 ++
 rtl/rf_wr_fifo.sv | 74 +++++++
 rtl/rf_write_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write path.
package rf_pkg;

    localparam int NREG  = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    // One queued register write.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rf_wr_t;

    // Write sources; also the encoding of the round-robin "last granted" bit.
    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_LD = 1'b1
    } src_e;

    // One-hot strobe for a destination; register 0 is hardwired and never strobed.
    function automatic logic [NREG-1:0] onehot_wr(input logic [AW-1:0] a);
        onehot_wr = (a == '0) ? '0 : (NREG'(1) << a);
    endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// In-order write queue. The whole entry array and per-slot valid bits are
// exposed so the parent can compute register hazards from the queued writes.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  rf_wr_t                   wr_entry,
    input  logic                     pop,
    output rf_wr_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output rf_wr_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]         valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rf_wr_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    // A push into a full queue is only legal when the head leaves the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Entry storage; contents need no reset because valid bits gate every use.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    // Pointers wrap naturally at DEPTH; count is unchanged on simultaneous push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PW-1:0] offset;
        assign offset      = PW'(gi) - rd_ptr_reg;
        assign valid[gi]   = ({1'b0, offset} < count_reg);
        assign entries[gi] = mem[gi];
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter between writeback and load-return writes, feeding an
// in-order queue that drains one one-hot register-bank write per cycle.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREG  = rf_pkg::NREG,
    parameter int AW    = rf_pkg::AW,
    parameter int DW    = rf_pkg::DW,
    parameter int DEPTH = rf_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    output logic            wb_ready,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_addr,
    input  logic [DW-1:0]   ld_data,
    output logic            ld_ready,
    output logic [NREG-1:0] WriteReg,
    output logic [DW-1:0]   WriteData,
    output logic [NREG-1:0] pending
);

    src_e                  last_reg;
    logic [NREG-1:0]       write_reg_reg;
    logic [DW-1:0]         write_data_reg;
    logic [NREG-1:0]       pend_comb;

    logic                  grant_wb;
    logic                  grant_ld;
    logic                  room;
    logic                  wb_xfer;
    logic                  ld_xfer;
    logic                  fifo_push;
    logic                  fifo_pop;
    rf_wr_t                fifo_in;
    rf_wr_t                fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    rf_wr_t [DEPTH-1:0]    fifo_entries;
    logic [DEPTH-1:0]      fifo_valid;

    // Grant, capacity check and queue push selection; no grants while in reset.
    always_comb begin
        grant_wb  = wb_valid && (!ld_valid || (last_reg == SRC_LD));
        grant_ld  = ld_valid && (!wb_valid || (last_reg == SRC_WB));
        fifo_pop  = !fifo_empty;
        room      = !fifo_full || fifo_pop;
        wb_ready  = !rst && grant_wb && room;
        ld_ready  = !rst && grant_ld && room;
        wb_xfer   = wb_valid && wb_ready;
        ld_xfer   = ld_valid && ld_ready;
        fifo_push = wb_xfer || ld_xfer;
        fifo_in   = wb_xfer ? rf_wr_t'{addr: wb_addr, data: wb_data}
                            : rf_wr_t'{addr: ld_addr, data: ld_data};
    end

    // Round-robin pointer moves only on an accepted transfer; reset favours wb.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= SRC_LD;
        end else if (wb_xfer) begin
            last_reg <= SRC_WB;
        end else if (ld_xfer) begin
            last_reg <= SRC_LD;
        end
    end

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .wr_entry (fifo_in),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .entries  (fifo_entries),
        .valid    (fifo_valid)
    );

    // Output stage: strobe the head each cycle it exists; data bus holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else if (fifo_pop) begin
            write_reg_reg  <= onehot_wr(fifo_head.addr);
            write_data_reg <= fifo_head.data;
        end else begin
            write_reg_reg  <= '0;
        end
    end

    // Hazard bitmap from state only: queued destinations plus the current strobe.
    always_comb begin
        pend_comb = write_reg_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_entries[i].addr != '0)) begin
                pend_comb[fifo_entries[i].addr] = 1'b1;
            end
        end
    end

    assign WriteReg  = write_reg_reg;
    assign WriteData = write_data_reg;
    assign pending   = pend_comb;

    // The FIFO's empty flag and its count must always agree.
    a_empty_count: assert property (@(posedge clk) disable iff (rst)
        fifo_empty == (fifo_count == '0));

endmodule
